// File: rtl/dependency_check.sv
// -----------------------------------------------------------------------------
// dependency_check
//
// Purpose: tracks the destination tags of the three in-flight stages (ex, dm,
// wb). From them it produces the operand forwarding selects for the
// instruction in decode, and it detects the one-cycle load-use hazard.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst        in   synchronous active-high reset
//   RA, RB     in   [4:0] decode source addresses
//   RW         in   [4:0] decode destination address
//   wr_en      in   decode instruction writes RW
//   is_load    in   decode instruction is a load (result appears on ans_dm)
//   use_A/B    in   decode instruction reads RA / RB
//   flush      in   kill the decode instruction (bubble enters ex)
//   mux_sel_A  out  [1:0] forwarding select for A (00 bank, 01 ex, 10 dm, 11 wb)
//   mux_sel_B  out  [1:0] forwarding select for B
//   RW_ex/dm/wb out [4:0] registered destination tags of each stage
//   stall      out  hold fetch/decode this cycle (combinational)
//   stall_cnt  out  [15:0] saturating count of stall cycles
// -----------------------------------------------------------------------------
module dependency_check (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  RA,
    input  logic [4:0]  RB,
    input  logic [4:0]  RW,
    input  logic        wr_en,
    input  logic        is_load,
    input  logic        use_A,
    input  logic        use_B,
    input  logic        flush,
    output logic [1:0]  mux_sel_A,
    output logic [1:0]  mux_sel_B,
    output logic [4:0]  RW_ex,
    output logic [4:0]  RW_dm,
    output logic [4:0]  RW_wb,
    output logic        stall,
    output logic [15:0] stall_cnt
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 16;

    localparam logic [1:0] SEL_BANK = 2'b00;
    localparam logic [1:0] SEL_EX   = 2'b01;
    localparam logic [1:0] SEL_DM   = 2'b10;
    localparam logic [1:0] SEL_WB   = 2'b11;

    // Stage entries. The load flag only matters while the producer sits in
    // ex, because by dm its result is already forwardable, so dm and wb do
    // not keep it.
    logic          ex_valid_q, ex_valid_d;
    logic          ex_wr_q,    ex_wr_d;
    logic          ex_load_q,  ex_load_d;
    logic [AW-1:0] ex_tag_q,   ex_tag_d;

    logic          dm_valid_q;
    logic          dm_wr_q;
    logic [AW-1:0] dm_tag_q;

    logic          wb_valid_q;
    logic          wb_wr_q;
    logic [AW-1:0] wb_tag_q;

    logic [CW-1:0] stall_cnt_q, stall_cnt_d;

    // Per-stage hit flags for each source operand.
    logic hit_ex_a, hit_dm_a, hit_wb_a;
    logic hit_ex_b, hit_dm_b, hit_wb_b;

    // A stage matches when it holds a live writer of the same register;
    // register 0 is an ordinary register here.
    always_comb begin
        hit_ex_a = ex_valid_q && ex_wr_q && (ex_tag_q == RA);
        hit_dm_a = dm_valid_q && dm_wr_q && (dm_tag_q == RA);
        hit_wb_a = wb_valid_q && wb_wr_q && (wb_tag_q == RA);
        hit_ex_b = ex_valid_q && ex_wr_q && (ex_tag_q == RB);
        hit_dm_b = dm_valid_q && dm_wr_q && (dm_tag_q == RB);
        hit_wb_b = wb_valid_q && wb_wr_q && (wb_tag_q == RB);
    end

    // Forwarding selects: the youngest matching producer wins.
    always_comb begin
        mux_sel_A = SEL_BANK;
        if (use_A) begin
            if (hit_ex_a)      mux_sel_A = SEL_EX;
            else if (hit_dm_a) mux_sel_A = SEL_DM;
            else if (hit_wb_a) mux_sel_A = SEL_WB;
        end
    end

    always_comb begin
        mux_sel_B = SEL_BANK;
        if (use_B) begin
            if (hit_ex_b)      mux_sel_B = SEL_EX;
            else if (hit_dm_b) mux_sel_B = SEL_DM;
            else if (hit_wb_b) mux_sel_B = SEL_WB;
        end
    end

    // Load-use hazard: the load in ex has no result yet. A flushed decode
    // instruction will never execute, so it cannot stall.
    always_comb begin
        stall = 1'b0;
        if (!flush && ex_load_q) begin
            stall = (use_A && hit_ex_a) || (use_B && hit_ex_b);
        end
    end

    // Next ex entry: the decode instruction, or a bubble on stall or flush.
    always_comb begin
        ex_valid_d = 1'b0;
        ex_wr_d    = 1'b0;
        ex_load_d  = 1'b0;
        ex_tag_d   = '0;
        if (!stall && !flush) begin
            ex_valid_d = 1'b1;
            ex_wr_d    = wr_en;
            ex_load_d  = is_load;
            ex_tag_d   = RW;
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != {CW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CW'(1);
        end
    end

    // Stage shift register and counter; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q  <= 1'b0;
            ex_wr_q     <= 1'b0;
            ex_load_q   <= 1'b0;
            ex_tag_q    <= '0;
            dm_valid_q  <= 1'b0;
            dm_wr_q     <= 1'b0;
            dm_tag_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_wr_q     <= 1'b0;
            wb_tag_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            wb_valid_q  <= dm_valid_q;
            wb_wr_q     <= dm_wr_q;
            wb_tag_q    <= dm_tag_q;
            dm_valid_q  <= ex_valid_q;
            dm_wr_q     <= ex_wr_q;
            dm_tag_q    <= ex_tag_q;
            ex_valid_q  <= ex_valid_d;
            ex_wr_q     <= ex_wr_d;
            ex_load_q   <= ex_load_d;
            ex_tag_q    <= ex_tag_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign RW_ex     = ex_tag_q;
    assign RW_dm     = dm_tag_q;
    assign RW_wb     = wb_tag_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_dependency_check.sv
// -----------------------------------------------------------------------------
// tb_dependency_check
//
// Purpose: testbench for dependency_check. It runs a set of directed pipeline
// scenarios, then random traffic. A queue-based model of in-flight
// instructions predicts each cycle's outputs into a scoreboard, and a monitor
// checks those predictions against the DUT at the falling edge.
// -----------------------------------------------------------------------------
module tb_dependency_check;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  RA, RB, RW;
    logic        wr_en, is_load, use_A, use_B, flush;
    logic [1:0]  mux_sel_A, mux_sel_B;
    logic [4:0]  RW_ex, RW_dm, RW_wb;
    logic        stall;
    logic [15:0] stall_cnt;

    dependency_check dut (
        .clk       (clk),
        .rst       (rst),
        .RA        (RA),
        .RB        (RB),
        .RW        (RW),
        .wr_en     (wr_en),
        .is_load   (is_load),
        .use_A     (use_A),
        .use_B     (use_B),
        .flush     (flush),
        .mux_sel_A (mux_sel_A),
        .mux_sel_B (mux_sel_B),
        .RW_ex     (RW_ex),
        .RW_dm     (RW_dm),
        .RW_wb     (RW_wb),
        .stall     (stall),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // In-flight instruction record; index 0 of the list is the youngest (ex).
    typedef struct {
        bit     v;
        bit     w;
        bit     l;
        int     t;
    } inst_t;

    typedef struct {
        int sa;
        int sb;
        int st;
        int rwe;
        int rwd;
        int rww;
        int cnt;
    } exp_t;

    inst_t in_flight[$];
    exp_t  sb_q[$];
    int    model_cnt;
    int    total = 0;
    int    bad   = 0;

    function automatic inst_t bubble();
        inst_t b;
        b.v = 1'b0; b.w = 1'b0; b.l = 1'b0; b.t = 0;
        return b;
    endfunction

    task automatic model_reset();
        in_flight.delete();
        for (int i = 0; i < 3; i++) in_flight.push_back(bubble());
        model_cnt = 0;
    endtask

    // Source code for an operand: 1 + age of the youngest writer, 0 if none.
    function automatic int pick(int addr, bit used);
        if (!used) return 0;
        for (int i = 0; i < 3; i++) begin
            if (in_flight[i].v && in_flight[i].w && in_flight[i].t == addr)
                return i + 1;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", name, got, want, $time);
        end
    endtask

    // Monitor: checks the scoreboard head against the DUT mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("mux_sel_A", int'(mux_sel_A), e.sa);
                chk("mux_sel_B", int'(mux_sel_B), e.sb);
                chk("stall",     int'(stall),     e.st);
                chk("RW_ex",     int'(RW_ex),     e.rwe);
                chk("RW_dm",     int'(RW_dm),     e.rwd);
                chk("RW_wb",     int'(RW_wb),     e.rww);
                chk("stall_cnt", int'(stall_cnt), e.cnt);
            end
        end
    end

    // One decode cycle: drive inputs, predict outputs, then advance the model.
    task automatic cycle(input bit r, input int ra, input int rb, input int rw,
                         input bit we, input bit ld, input bit ua, input bit ub,
                         input bit fl);
        exp_t  e;
        bit    hz;
        inst_t n;
        rst = r; RA = 5'(ra); RB = 5'(rb); RW = 5'(rw);
        wr_en = we; is_load = ld; use_A = ua; use_B = ub; flush = fl;

        e.sa  = pick(ra, ua);
        e.sb  = pick(rb, ub);
        hz    = !fl && in_flight[0].l && (e.sa == 1 || e.sb == 1);
        e.st  = int'(hz);
        e.rwe = in_flight[0].t;
        e.rwd = in_flight[1].t;
        e.rww = in_flight[2].t;
        e.cnt = model_cnt;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        if (r) begin
            model_reset();
        end else begin
            if (hz && model_cnt < 65535) model_cnt++;
            if (hz || fl) n = bubble();
            else begin
                n.v = 1'b1; n.w = we; n.l = ld; n.t = rw;
            end
            in_flight.push_front(n);
            void'(in_flight.pop_back());
        end
    endtask

    // Idle decode slot: reads nothing, writes nothing.
    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1; RA = '0; RB = '0; RW = '0;
        wr_en = 1'b0; is_load = 1'b0; use_A = 1'b0; use_B = 1'b0; flush = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // Reset state observed with idle inputs.
        idle();

        // ADD writes R5, then R5 is read from ex, dm, wb, then the bank.
        cycle(0, 0, 0, 5, 1, 0, 0, 0, 0);
        cycle(0, 5, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 5, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 5, 0, 1, 0, 0, 1, 0, 0);
        cycle(0, 5, 0, 1, 0, 0, 1, 0, 0);

        // Load R7 then use on B: one stall cycle, then forwarded from dm.
        cycle(0, 0, 0, 7, 1, 1, 0, 0, 0);
        cycle(0, 0, 7, 2, 1, 0, 0, 1, 0);
        cycle(0, 0, 7, 2, 1, 0, 0, 1, 0);
        idle();

        // Two consecutive writers of R3: the youngest one wins.
        cycle(0, 0, 0, 3, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 3, 1, 0, 0, 0, 0);
        cycle(0, 3, 3, 8, 1, 0, 1, 1, 0);

        // Load R9 followed by an unused read of R9: no stall.
        cycle(0, 0, 0, 9, 1, 1, 0, 0, 0);
        cycle(0, 9, 0, 1, 0, 0, 0, 0, 0);

        // Load-use hazard with a flush in the same cycle.
        cycle(0, 0, 0, 10, 1, 1, 0, 0, 0);
        cycle(0, 10, 0, 1, 1, 0, 1, 0, 1);
        cycle(0, 10, 0, 1, 0, 0, 1, 0, 0);
        idle();

        // Register 0 is ordinary.
        cycle(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Reset with R4 writers in every stage, including a pending hazard.
        cycle(0, 0, 0, 4, 1, 1, 0, 0, 0);
        cycle(0, 0, 0, 4, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 4, 1, 1, 0, 0, 0);
        cycle(1, 4, 4, 4, 1, 1, 1, 1, 0);
        cycle(0, 4, 4, 0, 0, 0, 1, 1, 0);

        // Random traffic on a small register range to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 59) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) < 2),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 9) == 0));
        end

        // Drain the scoreboard, bounded.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dependency_check.md
DEPENDENCY_CHECK -- requirements
Module: dependency_check

Interface
REQ-001 Parameters: none; register address width is 5 bits and data width is not visible to this block.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 RA  input  5  source A address of the instruction in decode.
REQ-005 RB  input  5  source B address of the instruction in decode.
REQ-006 RW  input  5  destination address of the instruction in decode.
REQ-007 wr_en  input  1  decode instruction writes RW.
REQ-008 is_load  input  1  decode instruction is a load; its result first appears on ans_dm.
REQ-009 use_A, use_B  input  1 each  decode instruction reads RA / RB (use_B=0 when the immediate is selected).
REQ-010 flush  input  1  kill the decode instruction; a bubble enters ex.
REQ-011 mux_sel_A, mux_sel_B  output  2 each  forwarding selects: 00 bank, 01 ans_ex, 10 ans_dm, 11 ans_wb.
REQ-012 RW_ex, RW_dm, RW_wb  output  5 each  destination tags of the ex, dm and wb stages; RW_dm drives the bank write address.
REQ-013 stall  output  1  hold fetch/decode this cycle.
REQ-014 stall_cnt  output  16  count of stall cycles, saturating.

Function
REQ-015 The block SHALL hold three stage entries (ex, dm, wb), each holding {valid, wr, load, tag[4:0]}.
REQ-016 On each edge without rst, the dm entry SHALL shift to wb and the ex entry SHALL shift to dm.
REQ-017 On the same edge, ex SHALL load {1, wr_en, is_load, RW} when stall=0 and flush=0; otherwise ex SHALL load a bubble (valid=0, wr=0, load=0, tag=0).
REQ-018 A stage SHALL match source X when its valid=1, its wr=1 and its tag equals X.
REQ-019 mux_sel_A SHALL be combinational with priority ex(01) > dm(10) > wb(11) > 00, evaluated against RA.
REQ-020 mux_sel_A SHALL be 00 when use_A=0; mux_sel_B SHALL follow the identical rule against RB and use_B.
REQ-021 All 32 register addresses, including 0, SHALL be ordinary; there is no hardwired zero.
REQ-022 stall SHALL be 1 (combinational) when the ex entry has load=1 and it matches RA with use_A=1, or RB with use_B=1; otherwise stall SHALL be 0.
REQ-023 While stall=1, mux_sel outputs SHALL still be driven; downstream ignores them.
REQ-024 The cycle after a stall, the load is in dm, so the same source SHALL select 10 and stall SHALL be 0; a load-use stall lasts exactly 1 cycle.
REQ-025 flush=1 SHALL force stall=0 in the same cycle; flush takes priority over a simultaneous load-use hazard.
REQ-026 RW_ex, RW_dm and RW_wb SHALL be the registered tags; a bubble shows tag 0 with valid=0.
REQ-027 stall_cnt SHALL increment by 1 on each edge where stall=1 and SHALL hold at 16'hFFFF with no wrap.
REQ-028 Back-to-back writers to the same tag SHALL resolve to the youngest stage per REQ-019.

Reset
REQ-029 On an edge with rst=1, all stage entries SHALL become bubbles and stall_cnt SHALL become 0, overriding flush and stall; the decode instruction is discarded.
REQ-030 After reset, the outputs SHALL be: mux_sel_A=mux_sel_B=00, stall=0, RW_ex=RW_dm=RW_wb=0.
REQ-031 rst asserted mid-stall SHALL clear stall from the following cycle.

Verification
REQ-032 Scenario: ADD writes R5, next cycle RA=5 use_A=1 -> mux_sel_A=01; next cycle -> 10; next cycle -> 11; next cycle -> 00.
REQ-033 Scenario: load writes R7, next cycle RB=7 use_B=1 -> stall=1 for 1 cycle, RW_ex=0 bubble, then mux_sel_B=10, stall=0, stall_cnt=1.
REQ-034 Scenario: writes to R3 in consecutive cycles, then RA=RB=3 -> both selects=01 (youngest wins).
REQ-035 Scenario: load writes R9, then RA=9 with use_A=0 -> stall=0, mux_sel_A=00.
REQ-036 Scenario: load-use hazard with flush=1 in the same cycle -> stall=0, ex bubble next edge, stall_cnt unchanged.
REQ-037 Scenario: rst=1 with all stages holding R4 writers -> next cycle RW_*=0, selects 00 for RA=4, stall_cnt=0.
